// File: rtl/serial_frame_packer.sv
// serial_frame_packer
// Buffers the non-stallable serializer byte stream in a small show-ahead FIFO
// and re-emits it as framed packets: SOF, 16-bit length, payload, checksum.
// The downstream side is a valid/ready byte interface. o_data and o_valid come
// straight from flops so the link stage sees clean, stable outputs.
module serial_frame_packer #(
   parameter int unsigned DEPTH    = 16,
   parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  i_serialized_output,
   input  logic        i_serialized_output_valid,
   input  logic [5:0]  i_RCC_BUFFER_LENGTH,
   output logic [7:0]  o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_frame_done,
   output logic [15:0] o_frame_cnt,
   output logic        o_overflow,
   output logic [15:0] o_drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SOF,
      S_LEN_H,
      S_LEN_L,
      S_PAYLOAD,
      S_CSUM
   } state_t;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [7:0]  fifo_mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  rem_q, rem_d;
   logic [7:0]  csum_q, csum_d;
   logic [7:0]  o_data_q, o_data_d;
   logic        o_valid_q, o_valid_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        overflow_q, overflow_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   logic        fifo_empty;
   logic        fifo_full;
   logic        xfer;
   logic        pop;
   logic        push;
   logic        drop;
   logic        zero_len_drop;
   logic [15:0] new_len;
   logic [7:0]  head_d;

   assign count_q    = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (AW+1)'(DEPTH));
   assign xfer       = o_valid_q && i_ready;
   assign new_len    = {8'b0, i_RCC_BUFFER_LENGTH, 2'b00};

   // FIFO push/pop decisions, pointer updates and drop accounting.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      pop           = (state_q == S_PAYLOAD) && xfer;
      zero_len_drop = (state_q == S_IDLE) && (i_RCC_BUFFER_LENGTH == 6'd0);
      push          = i_serialized_output_valid && !zero_len_drop && (!fifo_full || pop);
      drop          = i_serialized_output_valid && !push;
      wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, pop};
      count_d       = wr_ptr_d - rd_ptr_d;
      overflow_d    = overflow_q | (drop && !zero_len_drop);
      drop_cnt_d    = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   // Frame sequencing: state, latched length, remaining bytes, running checksum.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      rem_d       = rem_q;
      csum_d      = csum_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_SOF;
               len_d   = new_len;
               rem_d   = new_len[7:0];
               csum_d  = 8'd0;
            end
         end
         S_SOF: begin
            if (xfer) state_d = S_LEN_H;
         end
         S_LEN_H: begin
            if (xfer) begin
               csum_d  = csum_q + o_data_q;
               state_d = S_LEN_L;
            end
         end
         S_LEN_L: begin
            if (xfer) begin
               csum_d  = csum_q + o_data_q;
               // A zero-length frame has no payload to wait for.
               state_d = (len_q == 16'd0) ? S_CSUM : S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (xfer) begin
               csum_d = csum_q + o_data_q;
               rem_d  = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               // Leftover bytes start the next frame without an idle bubble.
               if (!fifo_empty) begin
                  state_d = S_SOF;
                  len_d   = new_len;
                  rem_d   = new_len[7:0];
                  csum_d  = 8'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next output byte/valid, computed from the next state so outputs are registered.
   always_comb begin
      // A byte written this cycle into an empty slot becomes the head immediately.
      head_d = (push && (rd_ptr_d == wr_ptr_q)) ? i_serialized_output
                                                : fifo_mem_q[rd_ptr_d[AW-1:0]];
      o_data_d  = 8'd0;
      o_valid_d = 1'b0;
      case (state_d)
         S_SOF: begin
            o_data_d  = SOF_BYTE;
            o_valid_d = 1'b1;
         end
         S_LEN_H: begin
            o_data_d  = len_d[15:8];
            o_valid_d = 1'b1;
         end
         S_LEN_L: begin
            o_data_d  = len_d[7:0];
            o_valid_d = 1'b1;
         end
         S_PAYLOAD: begin
            o_data_d  = head_d;
            o_valid_d = (count_d != '0);
         end
         S_CSUM: begin
            o_data_d  = ~csum_d + 8'd1;
            o_valid_d = 1'b1;
         end
         default: begin
            o_data_d  = 8'd0;
            o_valid_d = 1'b0;
         end
      endcase
   end

   // State and control registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         len_q       <= 16'd0;
         rem_q       <= 8'd0;
         csum_q      <= 8'd0;
         o_data_q    <= 8'd0;
         o_valid_q   <= 1'b0;
         frame_cnt_q <= 16'd0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         csum_q      <= csum_d;
         o_data_q    <= o_data_d;
         o_valid_q   <= o_valid_d;
         frame_cnt_q <= frame_cnt_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge CLK) begin
      // NOTE: storage is not reset; pointer reset alone makes stale contents unreachable.
      if (push && !RESET) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= i_serialized_output;
      end
   end

   assign o_data       = o_data_q;
   assign o_valid      = o_valid_q;
   assign o_frame_done = (state_q == S_CSUM) && xfer && !RESET;
   assign o_frame_cnt  = frame_cnt_q;
   assign o_overflow   = overflow_q;
   assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_serial_frame_packer.sv
// Directed testbench for serial_frame_packer: one task per scenario, each with
// hand-computed expected byte streams and inline comparisons.
module tb_serial_frame_packer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  i_serialized_output = 8'd0;
   logic        i_serialized_output_valid = 1'b0;
   logic [5:0]  i_RCC_BUFFER_LENGTH = 6'd0;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic        o_frame_done;
   logic [15:0] o_frame_cnt;
   logic        o_overflow;
   logic [15:0] o_drop_cnt;

   serial_frame_packer #(.DEPTH(16), .SOF_BYTE(8'hA5)) dut (
      .CLK                       (CLK),
      .RESET                     (RESET),
      .i_serialized_output       (i_serialized_output),
      .i_serialized_output_valid (i_serialized_output_valid),
      .i_RCC_BUFFER_LENGTH       (i_RCC_BUFFER_LENGTH),
      .o_data                    (o_data),
      .o_valid                   (o_valid),
      .i_ready                   (i_ready),
      .o_frame_done              (o_frame_done),
      .o_frame_cnt               (o_frame_cnt),
      .o_overflow                (o_overflow),
      .o_drop_cnt                (o_drop_cnt)
   );

   always #5 CLK = ~CLK;

   int         pass_cnt = 0;
   int         total_cnt = 0;
   logic [7:0] got [$];
   int         xfer_cyc [$];
   int         done_idx [$];
   int         done_cnt;
   int         cyc;
   int         first_valid_cyc;
   int         hold_err;
   logic       prev_stall;
   logic [7:0] prev_data;

   function automatic logic [7:0] got_at(input int i);
      return (i < int'(got.size())) ? got[i] : 8'hxx;
   endfunction

   task automatic clear_log();
      got.delete();
      xfer_cyc.delete();
      done_idx.delete();
      done_cnt        = 0;
      cyc             = 0;
      first_valid_cyc = -1;
      hold_err        = 0;
      prev_stall      = 1'b0;
      prev_data       = 8'd0;
   endtask

   // One clock: drive inputs, observe at the falling edge, log transfers.
   task automatic step(input logic v, input logic [7:0] d, input logic r);
      i_serialized_output_valid = v;
      i_serialized_output       = d;
      i_ready                   = r;
      @(negedge CLK);
      if (prev_stall && (!o_valid || (o_data !== prev_data))) hold_err++;
      if (o_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
      if (o_valid && r) begin
         got.push_back(o_data);
         xfer_cyc.push_back(cyc);
      end
      if (o_frame_done) begin
         done_cnt++;
         done_idx.push_back(int'(got.size()) - 1);
      end
      prev_stall = o_valid && !r;
      prev_data  = o_data;
      cyc++;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET                     = 1'b1;
      i_serialized_output_valid = 1'b0;
      i_serialized_output       = 8'd0;
      i_ready                   = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      clear_log();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      total_cnt++; if (o_data !== 8'd0) $display("FAIL reset_o_data: got %h expected 00", o_data); else pass_cnt++;
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b expected 0", o_valid); else pass_cnt++;
      total_cnt++; if (o_frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", o_frame_done); else pass_cnt++;
      total_cnt++; if (o_frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d expected 0", o_frame_cnt); else pass_cnt++;
      total_cnt++; if (o_overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", o_overflow); else pass_cnt++;
      total_cnt++; if (o_drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d expected 0", o_drop_cnt); else pass_cnt++;
      @(posedge CLK);
      #1;
   endtask

   // 1 word: 00+04+01+02+03+04 = 0E, checksum = -0E = F2.
   task automatic test_basic();
      logic [7:0] exp_b [8] = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
      do_reset();
      i_RCC_BUFFER_LENGTH = 6'd1;
      for (int k = 0; k < 16; k++) step(k < 4, 8'(k + 1), 1'b1);
      total_cnt++; if (got.size() !== 8) $display("FAIL basic_count: got %0d bytes expected 8", got.size()); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         total_cnt++;
         if (got_at(i) !== exp_b[i]) $display("FAIL basic_byte[%0d]: got %h expected %h", i, got_at(i), exp_b[i]);
         else pass_cnt++;
      end
      total_cnt++; if (first_valid_cyc !== 2) $display("FAIL basic_sof_latency: got cycle %0d expected 2", first_valid_cyc); else pass_cnt++;
      total_cnt++;
      if ((xfer_cyc.size() != 8) || (xfer_cyc[7] - xfer_cyc[0] !== 7))
         $display("FAIL basic_streaming: transfer span wrong, got %0d transfers expected 8 in 8 cycles", xfer_cyc.size());
      else pass_cnt++;
      total_cnt++;
      if ((done_cnt !== 1) || (done_idx[0] !== 7)) $display("FAIL basic_frame_done: got %0d pulses (first at %0d) expected 1 at 7", done_cnt, (done_cnt > 0) ? done_idx[0] : -1);
      else pass_cnt++;
      total_cnt++; if (o_frame_cnt !== 16'd1) $display("FAIL basic_frame_cnt: got %0d expected 1", o_frame_cnt); else pass_cnt++;
      total_cnt++; if (o_drop_cnt !== 16'd0) $display("FAIL basic_drop_cnt: got %0d expected 0", o_drop_cnt); else pass_cnt++;
   endtask

   task automatic test_ready_toggle();
      logic [7:0] exp_b [8] = '{8'hA5, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
      do_reset();
      i_RCC_BUFFER_LENGTH = 6'd1;
      for (int k = 0; k < 30; k++) step(k < 4, 8'(k + 1), (k % 2) == 0);
      total_cnt++; if (got.size() !== 8) $display("FAIL toggle_count: got %0d bytes expected 8", got.size()); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         total_cnt++;
         if (got_at(i) !== exp_b[i]) $display("FAIL toggle_byte[%0d]: got %h expected %h", i, got_at(i), exp_b[i]);
         else pass_cnt++;
      end
      total_cnt++; if (hold_err !== 0) $display("FAIL toggle_hold: got %0d unstable stall cycles expected 0", hold_err); else pass_cnt++;
      total_cnt++; if (o_drop_cnt !== 16'd0) $display("FAIL toggle_drop_cnt: got %0d expected 0", o_drop_cnt); else pass_cnt++;
      total_cnt++; if (done_cnt !== 1) $display("FAIL toggle_frame_done: got %0d pulses expected 1", done_cnt); else pass_cnt++;
      total_cnt++; if (o_frame_cnt !== 16'd1) $display("FAIL toggle_frame_cnt: got %0d expected 1", o_frame_cnt); else pass_cnt++;
   endtask

   // 8 words = 32 bytes into a 16-deep FIFO with the sink stalled: 16 kept, 16 dropped.
   task automatic test_overflow();
      do_reset();
      i_RCC_BUFFER_LENGTH = 6'd8;
      for (int k = 0; k < 70; k++) step(k < 32, 8'(k), k >= 40);
      total_cnt++; if (o_drop_cnt !== 16'd16) $display("FAIL ovf_drop_cnt: got %0d expected 16", o_drop_cnt); else pass_cnt++;
      total_cnt++; if (o_overflow !== 1'b1) $display("FAIL ovf_overflow: got %b expected 1", o_overflow); else pass_cnt++;
      total_cnt++; if (got.size() !== 19) $display("FAIL ovf_count: got %0d bytes expected 19", got.size()); else pass_cnt++;
      total_cnt++; if (got_at(2) !== 8'h20) $display("FAIL ovf_len_l: got %h expected 20", got_at(2)); else pass_cnt++;
      total_cnt++; if (got_at(18) !== 8'h0F) $display("FAIL ovf_last_payload: got %h expected 0F", got_at(18)); else pass_cnt++;
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL ovf_stall_valid: got %b expected 0", o_valid); else pass_cnt++;
      total_cnt++; if (o_frame_cnt !== 16'd0) $display("FAIL ovf_frame_cnt: got %0d expected 0", o_frame_cnt); else pass_cnt++;
   endtask

   task automatic test_zero_len();
      do_reset();
      i_RCC_BUFFER_LENGTH = 6'd0;
      for (int k = 0; k < 15; k++) step(k < 5, 8'(8'h50 + k), 1'b1);
      total_cnt++; if (got.size() !== 0) $display("FAIL zlen_output: got %0d bytes expected 0", got.size()); else pass_cnt++;
      total_cnt++; if (first_valid_cyc !== -1) $display("FAIL zlen_valid_seen: got cycle %0d expected none", first_valid_cyc); else pass_cnt++;
      total_cnt++; if (o_drop_cnt !== 16'd5) $display("FAIL zlen_drop_cnt: got %0d expected 5", o_drop_cnt); else pass_cnt++;
      total_cnt++; if (o_overflow !== 1'b0) $display("FAIL zlen_overflow: got %b expected 0", o_overflow); else pass_cnt++;
   endtask

   // Reset after payload byte 2; new frame 10,20,30,40: 04+A0 = A4, checksum 5C.
   task automatic test_reset_mid();
      logic [7:0] bytes_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] exp_b [8] = '{8'hA5, 8'h00, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h5C};
      int         k;
      do_reset();
      i_RCC_BUFFER_LENGTH = 6'd1;
      k = 0;
      while ((got.size() < 5) && (k < 20)) begin
         step(k < 4, (k < 4) ? bytes_a[k] : 8'h00, 1'b1);
         k++;
      end
      total_cnt++; if (got.size() !== 5) $display("FAIL rstmid_reach_payload: got %0d bytes expected 5 within budget", got.size()); else pass_cnt++;
      RESET                     = 1'b1;
      i_serialized_output_valid = 1'b0;
      i_ready                   = 1'b0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      total_cnt++; if (o_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", o_valid); else pass_cnt++;
      total_cnt++; if (o_data !== 8'd0) $display("FAIL rstmid_data: got %h expected 00", o_data); else pass_cnt++;
      total_cnt++; if (o_frame_cnt !== 16'd0) $display("FAIL rstmid_frame_cnt: got %0d expected 0", o_frame_cnt); else pass_cnt++;
      total_cnt++; if (done_cnt !== 0) $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt); else pass_cnt++;
      @(posedge CLK);
      #1;
      clear_log();
      for (int j = 0; j < 16; j++) step(j < 4, 8'((j + 1) * 16), 1'b1);
      total_cnt++; if (got.size() !== 8) $display("FAIL rstmid_count: got %0d bytes expected 8", got.size()); else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         total_cnt++;
         if (got_at(i) !== exp_b[i]) $display("FAIL rstmid_byte[%0d]: got %h expected %h", i, got_at(i), exp_b[i]);
         else pass_cnt++;
      end
      total_cnt++; if (o_frame_cnt !== 16'd1) $display("FAIL rstmid_frame_cnt_after: got %0d expected 1", o_frame_cnt); else pass_cnt++;
   endtask

   // FF x4: 04 + 3FC = 400 wraps to 00, checksum 00. 00 x4: 04, checksum FC.
   task automatic test_back_to_back();
      logic [7:0] exp_b [16] = '{8'hA5, 8'h00, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                                 8'hA5, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC};
      do_reset();
      i_RCC_BUFFER_LENGTH = 6'd1;
      for (int k = 0; k < 26; k++) step(k < 8, (k < 4) ? 8'hFF : 8'h00, 1'b1);
      total_cnt++; if (got.size() !== 16) $display("FAIL b2b_count: got %0d bytes expected 16", got.size()); else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         total_cnt++;
         if (got_at(i) !== exp_b[i]) $display("FAIL b2b_byte[%0d]: got %h expected %h", i, got_at(i), exp_b[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if ((xfer_cyc.size() != 16) || (xfer_cyc[15] - xfer_cyc[0] !== 15))
         $display("FAIL b2b_no_gap: got %0d transfers, not 16 consecutive cycles", xfer_cyc.size());
      else pass_cnt++;
      total_cnt++;
      if ((done_cnt !== 2) || (done_idx[0] !== 7) || (done_idx[1] !== 15))
         $display("FAIL b2b_frame_done: got %0d pulses expected 2 at bytes 7 and 15", done_cnt);
      else pass_cnt++;
      total_cnt++; if (o_frame_cnt !== 16'd2) $display("FAIL b2b_frame_cnt: got %0d expected 2", o_frame_cnt); else pass_cnt++;
   endtask

   initial begin
      clear_log();
      test_reset();
      test_basic();
      test_ready_toggle();
      test_overflow();
      test_zero_len();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
